// File: rtl/dispense_pkg.sv
// dispense_pkg: shared types and constants for the two-channel chute dispense arbiter.
package dispense_pkg;
    localparam int NUM_CH = 2;
    localparam int PEND_W = 3;
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, JAM} state_t;
endpackage

// File: rtl/pend_counter.sv
// pend_counter: saturating up/down counter of circles owed to one channel, with sticky overflow.
module pend_counter
    import dispense_pkg::*;
#(
    parameter int PEND_MAX = 7
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic [1:0]        drop,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              overflow
);
    localparam logic [PEND_W:0] MAX_V = (PEND_W+1)'(PEND_MAX);
    logic [PEND_W:0] sum;
    logic            sat;
    // One bit of headroom so a drop on a full counter is detected rather than wrapped.
    always_comb begin
        sum = {1'b0, count} + {{(PEND_W-1){1'b0}}, drop} - {{PEND_W{1'b0}}, dec};
        sat = sum > MAX_V;
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= sat ? MAX_V[PEND_W-1:0] : sum[PEND_W-1:0];
            overflow <= overflow | sat;
        end
    end
endmodule

// File: rtl/dispense_arbiter.sv
// dispense_arbiter: round-robin arbitration of two vendor channels onto one chute,
// with per-channel pending counters and a sticky jam on chute timeout.
module dispense_arbiter
    import dispense_pkg::*;
#(
    parameter int TIMEOUT  = 8,
    parameter int PEND_MAX = 7
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic [1:0]        drop0,
    input  logic [1:0]        drop1,
    input  logic              chute_done,
    output logic              chute_go,
    output logic              chute_sel,
    output logic [PEND_W-1:0] pending0,
    output logic [PEND_W-1:0] pending1,
    output logic              overflow0,
    output logic              overflow1,
    output logic              jam
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t              state, state_n;
    logic                last, last_n, sel, sel_n, pick;
    logic [TW-1:0]       tcnt, tcnt_n;
    logic [NUM_CH-1:0]   busy;
    assign busy      = {pending1 != '0, pending0 != '0};
    assign pick      = (&busy) ? ~last : busy[1];
    assign chute_go  = state == GRANT;
    assign jam       = state == JAM;
    assign chute_sel = sel;
    always_comb begin
        state_n = state;
        sel_n   = sel;
        last_n  = last;
        tcnt_n  = tcnt;
        case (state)
            IDLE: if (|busy) begin
                state_n = GRANT;
                sel_n   = pick;
                last_n  = pick;
            end
            GRANT: begin
                state_n = WAIT;
                tcnt_n  = '0;
            end
            WAIT: begin
                tcnt_n  = tcnt + 1'b1;
                state_n = chute_done ? IDLE : (tcnt == TW'(TIMEOUT - 1)) ? JAM : WAIT;
            end
            JAM: state_n = JAM;
            default: state_n = IDLE;
        endcase
    end
    // last resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            last  <= last_n;
            tcnt  <= tcnt_n;
        end
    end
    pend_counter #(.PEND_MAX(PEND_MAX)) u_pend0 (
        .clock    (clock),
        .reset_L  (reset_L),
        .drop     (drop0),
        .dec      (chute_go & ~sel),
        .count    (pending0),
        .overflow (overflow0)
    );
    pend_counter #(.PEND_MAX(PEND_MAX)) u_pend1 (
        .clock    (clock),
        .reset_L  (reset_L),
        .drop     (drop1),
        .dec      (chute_go & sel),
        .count    (pending1),
        .overflow (overflow1)
    );
endmodule
